// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared FSM states, pixel type and underrun colour for the HDMI line fetcher
package hdmi_pkg;
   typedef enum logic [2:0] {IDLE, REQ, DATA, DRAIN, LINE_DONE} state_t;
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;
   localparam logic [23:0] UNDERRUN_RGB_DEF = 24'hFF00FF;
endpackage

// File: rtl/hdmi_pixel_fifo.sv
// hdmi_pixel_fifo: synchronous first-word-fall-through pixel FIFO
// Ports: clk_pixel/rst (async, active-high), flush (drop all entries),
//        wr_en/wr_data (push), rd_en (pop), rd_data (head pixel),
//        empty, count (occupancy 0..DEPTH).
// A push and a pop on an empty FIFO pass the pixel straight through, so the
// occupancy stays at zero; on a full FIFO the pop frees the slot being written.
import hdmi_pkg::*;
module hdmi_pixel_fifo #(
   parameter int DEPTH = 64,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk_pixel,
   input  logic          rst,
   input  logic          flush,
   input  logic          wr_en,
   input  rgb_t          wr_data,
   input  logic          rd_en,
   output rgb_t          rd_data,
   output logic          empty,
   output logic [AW:0]   count
);
   rgb_t mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic full, do_wr, do_rd;
   always_comb begin
      empty = count == '0;
      full = count == (AW+1)'(DEPTH);
      do_rd = rd_en && !empty;
      do_wr = wr_en && !(empty && rd_en) && (!full || rd_en);
      rd_data = mem[rd_ptr];
   end
   always_ff @(posedge clk_pixel or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_wr);
         rd_ptr <= rd_ptr + AW'(do_rd);
         count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
   always_ff @(posedge clk_pixel)
      if (do_wr) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/hdmi_line_fetch.sv
// hdmi_line_fetch: fetches framebuffer lines in bursts into a pixel FIFO for HDMI scan-out
// Ports: clk_pixel/rst (async, active-high); fb_base (field start, sampled on next_field);
//        fetch_next/next_line/next_field (scan-out timing); red/green/blue (FIFO head);
//        mem_req/mem_addr/mem_ack (burst request); mem_rdata/mem_rvalid (read beats);
//        underrun (sticky empty-pop flag).
// Build option HDMI_UNDERRUN_CNT_EN adds underrun_cnt[15:0], a saturating empty-pop count.
import hdmi_pkg::*;
module hdmi_line_fetch #(
   parameter int          H_PIXELS     = 640,
   parameter int          V_LINES      = 480,
   parameter int          BURST        = 16,
   parameter int          FIFO_DEPTH   = 64,
   parameter logic [23:0] UNDERRUN_RGB = UNDERRUN_RGB_DEF
) (
   input  logic        clk_pixel,
   input  logic        rst,
   input  logic [31:0] fb_base,
   input  logic        fetch_next,
   input  logic        next_line,
   input  logic        next_field,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        underrun
`ifdef HDMI_UNDERRUN_CNT_EN
   ,output logic [15:0] underrun_cnt
`endif
);
   localparam int FAW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(BURST) + 1;
   localparam int PW = $clog2(H_PIXELS + 1);
   localparam int LW = $clog2(V_LINES + 1);
   state_t state, nxt;
   logic [31:0] line_addr, addr, req_addr;
   logic [PW-1:0] pix_left;
   logic [BW-1:0] bcnt;
   logic [LW-1:0] line_cnt;
   logic acked, nl_pend;
   logic wr, empty, pop_empty, start, burst_done, take_line, drained;
   logic [FAW:0] fcount;
   rgb_t beat, head, pix;
   logic unused_hi;
   assign unused_hi = ^mem_rdata[31:24];
   hdmi_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_pixel(clk_pixel),
      .rst(rst),
      .flush(next_field),
      .wr_en(wr),
      .wr_data(beat),
      .rd_en(fetch_next),
      .rd_data(head),
      .empty(empty),
      .count(fcount)
   );
   // mem_addr holds the accepted request address while a request is pending, even
   // across a next_field that has already reloaded the fetch address.
   always_comb begin
      beat = rgb_t'(mem_rdata[23:0]);
      wr = state == DATA && mem_rvalid;
      pop_empty = fetch_next && empty && !wr;
      start = pix_left != '0 && (FAW+1)'(FIFO_DEPTH) - fcount >= (FAW+1)'(BURST);
      burst_done = wr && bcnt == BW'(BURST - 1);
      take_line = (next_line || nl_pend) && line_cnt != LW'(V_LINES - 1);
      drained = acked && bcnt == BW'(BURST);
      mem_req = state == REQ || (state == DRAIN && !acked);
      mem_addr = mem_req ? req_addr : addr;
      pix = !empty ? head : !fetch_next ? '0 : wr ? beat : UNDERRUN_RGB;
      red = pix.r;
      green = pix.g;
      blue = pix.b;
      nxt = state;
      case (state)
         IDLE:      nxt = start ? REQ : IDLE;
         REQ:       nxt = mem_ack ? DATA : REQ;
         DATA:      nxt = !burst_done ? DATA : pix_left <= PW'(BURST) ? LINE_DONE : IDLE;
         DRAIN:     nxt = drained ? IDLE : DRAIN;
         LINE_DONE: nxt = take_line ? IDLE : LINE_DONE;
         default:   nxt = IDLE;
      endcase
      if (next_field) nxt = (state == REQ || state == DATA || state == DRAIN) ? DRAIN : IDLE;
   end
   always_ff @(posedge clk_pixel or posedge rst)
      if (rst) begin
         state <= IDLE;
         line_addr <= '0;
         addr <= '0;
         req_addr <= '0;
         pix_left <= '0;
         bcnt <= '0;
         line_cnt <= '0;
         acked <= 1'b0;
         nl_pend <= 1'b0;
         underrun <= 1'b0;
      end else begin
         state <= nxt;
         if (pop_empty) underrun <= 1'b1;
         if (next_line && state != LINE_DONE) nl_pend <= 1'b1;
         if (state == IDLE && start) req_addr <= addr;
         if (state == REQ && mem_ack) bcnt <= '0;
         if (wr || (state == DRAIN && acked && mem_rvalid)) bcnt <= bcnt + 1'b1;
         if (state == DRAIN && !acked && mem_ack) begin
            acked <= 1'b1;
            bcnt <= '0;
         end
         if (burst_done) begin
            addr <= addr + 32'(4 * BURST);
            pix_left <= pix_left - PW'(BURST);
         end
         if (state == LINE_DONE && take_line) begin
            line_addr <= line_addr + 32'(4 * H_PIXELS);
            addr <= line_addr + 32'(4 * H_PIXELS);
            pix_left <= PW'(H_PIXELS);
            line_cnt <= line_cnt + 1'b1;
            nl_pend <= 1'b0;
         end
         if (next_field) begin
            line_addr <= fb_base;
            addr <= fb_base;
            pix_left <= PW'(H_PIXELS);
            line_cnt <= '0;
            nl_pend <= 1'b0;
            underrun <= 1'b0;
            if (state == REQ) begin
               acked <= mem_ack;
               bcnt <= '0;
            end else if (state == DATA) acked <= 1'b1;
         end
      end
`ifdef HDMI_UNDERRUN_CNT_EN
   always_ff @(posedge clk_pixel or posedge rst)
      if (rst) underrun_cnt <= '0;
      else if (next_field) underrun_cnt <= '0;
      else if (pop_empty && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 1'b1;
`endif
endmodule

// File: doc/hdmi_line_fetch.md
HDMI_LINE_FETCH -- requirements
Module: hdmi_line_fetch

Interface
REQ-001 Parameter H_PIXELS, default 640, pixels per visible line.
REQ-002 Parameter V_LINES, default 480, visible lines per field.
REQ-003 Parameter BURST, default 16, pixels per memory burst (power of two).
REQ-004 Parameter FIFO_DEPTH, default 64, pixel FIFO entries (power of two, >= 2*BURST).
REQ-005 Parameter UNDERRUN_RGB, default 24'hFF00FF, colour driven on underrun.
REQ-006 clk_pixel  in  1  pixel clock; the only clock.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 fb_base  in  32  framebuffer byte address; sampled on next_field.
REQ-009 fetch_next  in  1  consumer pops one pixel this cycle.
REQ-010 next_line  in  1  one-cycle pulse: current visible line finished.
REQ-011 next_field  in  1  one-cycle pulse: field finished, restart at line 0.
REQ-012 red, green, blue  out  8 each  FIFO head pixel (first-word-fall-through).
REQ-013 mem_req, mem_addr  out  1, 32  burst request and word-aligned byte address.
REQ-014 mem_ack  in  1  request accepted this cycle.
REQ-015 mem_rdata, mem_rvalid  in  32, 1  read beat, pixel in bits [23:0] as RRGGBB.
REQ-016 underrun  out  1  sticky: pop occurred while FIFO empty.

Function
REQ-017 FSM states: IDLE, REQ, DATA, DRAIN, LINE_DONE.
REQ-018 IDLE -> REQ when FIFO free entries >= BURST and pixels remaining in line > 0.
REQ-019 REQ: mem_req=1 with mem_addr stable until mem_ack; mem_ack -> DATA.
REQ-020 DATA: each mem_rvalid writes one pixel into the FIFO; after BURST beats, mem_addr advances by 4*BURST and the FSM goes to LINE_DONE if the line is exhausted, otherwise IDLE.
REQ-021 LINE_DONE: next_line advances the line address to line start + 4*H_PIXELS and goes to IDLE; after V_LINES lines, next_line is ignored.
REQ-022 next_field in any state: flush the FIFO, reload the line address from fb_base, line count=0, clear underrun.
REQ-023 A next_field arriving in REQ or DATA goes to DRAIN, which discards the remaining beats of the accepted burst (REQ with no ack yet: finish the ack first), then goes to IDLE.
REQ-024 A next_line before LINE_DONE is latched and honoured on reaching LINE_DONE; a second latched pulse is not counted.
REQ-025 Pop with FIFO empty: outputs = UNDERRUN_RGB, underrun=1, FIFO unchanged.
REQ-026 Simultaneous write and pop on a full or empty FIFO shall both succeed; occupancy is unchanged.
REQ-027 Beat-to-output latency: a beat written into an empty FIFO appears on red/green/blue the next cycle.
REQ-028 Address arithmetic is 32-bit modulo 2^32 with silent wrap.

Reset
REQ-029 On rst: state IDLE, FIFO empty, mem_req=0, mem_addr=0, line count=0, underrun=0, red/green/blue=0.
REQ-030 After rst, no request is issued before the first next_field.

Configuration
REQ-031 HDMI_UNDERRUN_CNT_EN defined: adds output underrun_cnt[15:0], which increments once per empty pop, saturates at 16'hFFFF, and clears on next_field and on rst.
REQ-032 HDMI_UNDERRUN_CNT_EN undefined: no underrun_cnt port and no counter logic.

Structure
REQ-033 A shared package hdmi_pkg holds the FSM state enum, the RGB pixel typedef and the UNDERRUN_RGB default.
REQ-034 The FIFO is one sub-module, hdmi_pixel_fifo: synchronous FWFT, with occupancy output.

Verification
REQ-035 Reset, next_field with fb_base=0x1000, mem_ack one cycle later -> mem_addr=0x1000, then 0x1040 after 16 beats.
REQ-036 Full line with immediate ack and data -> exactly 40 bursts, LINE_DONE, then next_line -> mem_addr=0x1000+2560.
REQ-037 fetch_next held with no memory data -> red/green/blue=FF/00/FF and underrun=1; next_field clears underrun.
REQ-038 next_field after beat 5 of a burst -> remaining 11 beats discarded, FIFO empty, next request at the new fb_base.
REQ-039 FIFO filled to 64 entries -> no mem_req until occupancy <= 48; simultaneous pop+write at full keeps occupancy at 64.
REQ-040 HDMI_UNDERRUN_CNT_EN: 70000 empty pops -> underrun_cnt=16'hFFFF.
